lvds_align_ctrl: RTL and testbench

LVDS_ALIGN_CTRL -- requirements
Module: lvds_align_ctrl

---
 rtl/lvds_align_ctrl.sv | 146 ++++++++++++++
 tb/tb_lvds_align_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_align_ctrl.sv
// rtl/lvds_align_ctrl.sv - per-lane LVDS word alignment via bitslip; post-lock monitor under LVDS_ALIGN_MONITOR_EN
module lvds_align_ctrl #(
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 10,
    parameter int WAIT_CYCLES = 4,
    parameter int CONFIRM_CNT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       pattern,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    output logic [LANES-1:0]            bitslip,
    output logic                        busy,
    output logic                        done,
    output logic [LANES-1:0]            lane_ok,
    output logic                        error,
    output logic                        lock_lost
);

    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SLIP_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LANES - 1);
    localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(DATA_WIDTH);
    localparam logic [2:0]        MATCH_MAX = 3'(CONFIRM_CNT);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, COMPARE, SLIP, WAIT, NEXT, DONE} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [SLIP_W-1:0]  slip_cnt, slip_d;
    logic [2:0]         match_cnt, match_d;
    logic [3:0]         wait_cnt, wait_d;
    logic [LANES-1:0]   lane_ok_d;
    logic               error_d, lock_lost_d;
    logic               lane_match;

    assign lane_match = (data_in[idx*DATA_WIDTH +: DATA_WIDTH] == pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            slip_cnt  <= '0;
            match_cnt <= '0;
            wait_cnt  <= '0;
            lane_ok   <= '0;
            error     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            slip_cnt  <= slip_d;
            match_cnt <= match_d;
            wait_cnt  <= wait_d;
            lane_ok   <= lane_ok_d;
            error     <= error_d;
            lock_lost <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        slip_d      = slip_cnt;
        match_d     = match_cnt;
        wait_d      = wait_cnt;
        lane_ok_d   = lane_ok;
        error_d     = error;
        lock_lost_d = lock_lost;
        bitslip     = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_d     = COMPARE;
                    idx_d       = '0;
                    slip_d      = '0;
                    match_d     = '0;
                    wait_d      = '0;
                    lane_ok_d   = '0;
                    error_d     = 1'b0;
                    lock_lost_d = 1'b0;
                end
`ifdef LVDS_ALIGN_MONITOR_EN
                else if (state == DONE) begin
                    // Any locked lane that drifts off pattern loses its lock flag.
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_ok[i] && (data_in[i*DATA_WIDTH +: DATA_WIDTH] != pattern)) begin
                            lane_ok_d[i] = 1'b0;
                            lock_lost_d  = 1'b1;
                        end
                    end
                end
`endif
            end
            COMPARE: begin
                busy = 1'b1;
                if (lane_match) begin
                    match_d = match_cnt + 3'd1;
                    if (match_cnt + 3'd1 == MATCH_MAX) begin
                        lane_ok_d[idx] = 1'b1;
                        state_d        = NEXT;
                    end
                end else begin
                    match_d = '0;
                    if (slip_cnt == SLIP_MAX) begin
                        error_d = 1'b1;
                        state_d = NEXT;
                    end else begin
                        state_d = SLIP;
                    end
                end
            end
            SLIP: begin
                busy         = 1'b1;
                bitslip[idx] = 1'b1;
                slip_d       = slip_cnt + 1'b1;
                wait_d       = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) state_d = COMPARE;
                else                       wait_d  = wait_cnt + 4'd1;
            end
            NEXT: begin
                busy    = 1'b1;
                slip_d  = '0;
                match_d = '0;
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// tb/tb_lvds_align_ctrl.sv - directed self-checking bench for lvds_align_ctrl
module tb_lvds_align_ctrl;

    localparam int LANES = 4;
    localparam int DW    = 10;
    localparam int WC    = 4;
    localparam int CC    = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [DW-1:0]       pattern = 10'h3E0;
    logic [LANES*DW-1:0] data_in;
    logic [LANES-1:0]    bitslip;
    logic                busy, done, error, lock_lost;
    logic [LANES-1:0]    lane_ok;

    int n_cmp = 0;
    int n_bad = 0;

    int need [LANES];
    bit dead [LANES];
    bit bad0 = 1'b0;
    int slips [LANES];
    int gap_err = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit prev_valid = 1'b0;

    lvds_align_ctrl #(.LANES(LANES), .DATA_WIDTH(DW), .WAIT_CYCLES(WC), .CONFIRM_CNT(CC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .data_in(data_in),
        .bitslip(bitslip), .busy(busy), .done(done), .lane_ok(lane_ok),
        .error(error), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int n);
        logic [DW-1:0] r;
        r = v;
        for (int k = 0; k < n; k++) r = {r[DW-2:0], r[DW-1]};
        return r;
    endfunction

    // Deserializer model: lane is off by need[i] bits until that many slips arrive.
    always_comb begin
        data_in = '0;
        for (int i = 0; i < LANES; i++) begin
            if (dead[i])                          data_in[i*DW +: DW] = ~pattern;
            else if (i == 0 && bad0 && slips[0] == 0) data_in[i*DW +: DW] = ~pattern;
            else if (slips[i] >= need[i])         data_in[i*DW +: DW] = pattern;
            else                                  data_in[i*DW +: DW] = rotl(pattern, need[i] - slips[i]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) slips[i] <= 0;
            prev_valid <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (bitslip != '0) begin
                if ($countones(bitslip) != 1) gap_err <= gap_err + 1;
                else if (prev_valid && (cyc - last_cyc) < WC + 2) gap_err <= gap_err + 1;
                prev_valid <= 1'b1;
                last_cyc   <= cyc;
                for (int i = 0; i < LANES; i++) if (bitslip[i]) slips[i] <= slips[i] + 1;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < LANES; i++) begin
            need[i] = 0;
            dead[i] = 1'b0;
        end
        bad0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_train(input int restart_at, output int cycles, output bit ok);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (cycles < 300 && !done) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == restart_at);
        end
        start = 1'b0;
        ok = done;
    endtask

    task automatic test_reset();
        clear_model();
        rst_n = 1'b0;
        #13;
        n_cmp++; if ({busy, done, error, lock_lost, lane_ok, bitslip} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got %b exp 0", {busy, done, error, lock_lost, lane_ok, bitslip}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, bitslip} !== '0) begin
            n_bad++; $display("FAIL idle_no_start got %b exp 0", {busy, done, bitslip}); end
    endtask

    task automatic test_aligned();
        int c; bit ok;
        clear_model();
        do_reset();
        run_train(0, c, ok);
        n_cmp++; if (c !== 4 * (CC + 1) || !ok) begin
            n_bad++; $display("FAIL aligned_cycles got %0d exp %0d", c, 4 * (CC + 1)); end
        n_cmp++; if (lane_ok !== 4'b1111 || error !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL aligned_flags got ok=%b err=%b busy=%b exp 1111/0/0", lane_ok, error, busy); end
        n_cmp++; if (slips[0] + slips[1] + slips[2] + slips[3] !== 0) begin
            n_bad++; $display("FAIL aligned_no_slip got %0d exp 0", slips[0] + slips[1] + slips[2] + slips[3]); end
    endtask

    task automatic test_slip_lane2();
        int c; bit ok;
        clear_model();
        need[2] = 3;
        do_reset();
        run_train(10, c, ok);
        n_cmp++; if (c !== 4 * (CC + 1) + 3 * (WC + 2) || !ok) begin
            n_bad++; $display("FAIL slip2_cycles got %0d exp %0d", c, 4 * (CC + 1) + 3 * (WC + 2)); end
        n_cmp++; if (slips[2] !== 3 || slips[0] + slips[1] + slips[3] !== 0) begin
            n_bad++; $display("FAIL slip2_pulses got %0d/%0d exp 3/0", slips[2], slips[0] + slips[1] + slips[3]); end
        n_cmp++; if (lane_ok !== 4'b1111 || error !== 1'b0) begin
            n_bad++; $display("FAIL slip2_flags got ok=%b err=%b exp 1111/0", lane_ok, error); end
        n_cmp++; if (gap_err !== 0) begin
            n_bad++; $display("FAIL slip2_spacing got %0d exp 0", gap_err); end
    endtask

    task automatic test_fail_lane1();
        int c; bit ok;
        clear_model();
        dead[1] = 1'b1;
        do_reset();
        run_train(0, c, ok);
        n_cmp++; if (c !== 3 * (CC + 1) + DW * (WC + 2) + 2 || !ok) begin
            n_bad++; $display("FAIL fail1_cycles got %0d exp %0d", c, 3 * (CC + 1) + DW * (WC + 2) + 2); end
        n_cmp++; if (slips[1] !== DW) begin
            n_bad++; $display("FAIL fail1_pulses got %0d exp %0d", slips[1], DW); end
        n_cmp++; if (lane_ok !== 4'b1101 || error !== 1'b1 || done !== 1'b1) begin
            n_bad++; $display("FAIL fail1_flags got ok=%b err=%b done=%b exp 1101/1/1", lane_ok, error, done); end
        dead[1] = 1'b0;
    endtask

    task automatic test_broken_confirm();
        int c;
        clear_model();
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bad0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (lane_ok[0] !== 1'b0 || slips[0] !== 1) begin
            n_bad++; $display("FAIL broken_early got ok0=%b slips=%0d exp 0/1", lane_ok[0], slips[0]); end
        @(posedge clk);
        #1;
        n_cmp++; if (lane_ok[0] !== 1'b1) begin
            n_bad++; $display("FAIL broken_lock got %b exp 1", lane_ok[0]); end
        c = 11;
        while (c < 300 && !done) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++; if (c !== 24 || lane_ok !== 4'b1111 || slips[0] !== 1) begin
            n_bad++; $display("FAIL broken_total got c=%0d ok=%b slips=%0d exp 24/1111/1", c, lane_ok, slips[0]); end
        bad0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c; bit ok;
        clear_model();
        need[1] = 2;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1 || slips[1] !== 1 || lane_ok !== 4'b0001 || bitslip !== '0) begin
            n_bad++; $display("FAIL mid_prewait got busy=%b slips=%0d ok=%b bs=%b exp 1/1/0001/0", busy, slips[1], lane_ok, bitslip); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, error, lock_lost, lane_ok, bitslip} !== '0) begin
            n_bad++; $display("FAIL mid_reset got %b exp 0", {busy, done, error, lock_lost, lane_ok, bitslip}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (slips[1] !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL mid_quiet got slips=%0d busy=%b done=%b exp 0/0/0", slips[1], busy, done); end
        run_train(0, c, ok);
        n_cmp++; if (c !== 4 * (CC + 1) + 2 * (WC + 2) || lane_ok !== 4'b1111 || !ok) begin
            n_bad++; $display("FAIL mid_retrain got c=%0d ok=%b exp %0d/1111", c, lane_ok, 4 * (CC + 1) + 2 * (WC + 2)); end
    endtask

    task automatic test_monitor();
        int c; bit ok;
        logic [LANES-1:0] exp_ok;
        logic             exp_lost;
`ifdef LVDS_ALIGN_MONITOR_EN
        exp_ok = 4'b0111; exp_lost = 1'b1;
`else
        exp_ok = 4'b1111; exp_lost = 1'b0;
`endif
        dead[3] = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (lane_ok !== exp_ok || lock_lost !== exp_lost || done !== 1'b1) begin
            n_bad++; $display("FAIL monitor got ok=%b lost=%b exp %b/%b", lane_ok, lock_lost, exp_ok, exp_lost); end
        dead[3] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (lock_lost !== exp_lost || lane_ok !== exp_ok) begin
            n_bad++; $display("FAIL monitor_sticky got ok=%b lost=%b exp %b/%b", lane_ok, lock_lost, exp_ok, exp_lost); end
        run_train(0, c, ok);
        n_cmp++; if (lock_lost !== 1'b0 || lane_ok !== 4'b1111 || c !== 4 * (CC + 1) || !ok) begin
            n_bad++; $display("FAIL monitor_restart got lost=%b ok=%b c=%0d exp 0/1111/%0d", lock_lost, lane_ok, c, 4 * (CC + 1)); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_slip_lane2();
        test_fail_lane1();
        test_broken_confirm();
        test_reset_mid();
        test_monitor();
        n_cmp++; if (gap_err !== 0) begin
            n_bad++; $display("FAIL pulse_rules got %0d exp 0", gap_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
